// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two valid/ready requesters
// (port 0 = execute datapath, port 1 = address/branch helper). One request is
// accepted in IDLE, the ALU result is registered and held on the winning
// response port until consumed.
// Optional build macro: ALU_ARB_RR_EN -> round-robin on contention; otherwise
// port 0 has fixed priority.
module alu_share_arb #(
  parameter int unsigned N   = 32,
  parameter int unsigned OPW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_src1,
  input  logic [N-1:0]   req0_src2,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_src1,
  input  logic [N-1:0]   req1_src2,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [N-1:0]   rsp0_res,
  output logic [3:0]     rsp0_flags,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [N-1:0]   rsp1_res,
  output logic [3:0]     rsp1_flags,
  output logic [N-1:0]   alu_src1,
  output logic [N-1:0]   alu_src2,
  output logic [OPW-1:0] alu_op,
  input  logic [N-1:0]   alu_res,
  input  logic [3:0]     alu_flags
);

  localparam int unsigned FW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic [N-1:0]    res_q, res_d;
  logic [FW-1:0]   flags_q, flags_d;
  logic            grant_c;
  logic            alu_sel1_c;
  logic            accept_c;

  // Arbitration: which port would win if a request were accepted this cycle
  always_comb begin
    grant_c = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end else begin
      grant_c = ~req0_valid;
    end
`else
    grant_c = ~req0_valid;
`endif
  end

  // Request handshake and ALU operand mux (port 0 operands when nothing is granted)
  always_comb begin
    req0_ready = (state_q == IDLE) && !reset && req0_valid && !grant_c;
    req1_ready = (state_q == IDLE) && !reset && req1_valid && grant_c;
    accept_c   = req0_ready || req1_ready;
    alu_sel1_c = (state_q == IDLE) && req1_valid && grant_c;
    alu_src1   = alu_sel1_c ? req1_src1 : req0_src1;
    alu_src2   = alu_sel1_c ? req1_src2 : req0_src2;
    alu_op     = alu_sel1_c ? req1_op   : req0_op;
  end

  // Next-state logic: capture the ALU on accept, release on response handshake
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    res_d        = res_q;
    flags_d      = flags_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d      = RESP;
          last_grant_d = grant_c;
          res_d        = alu_res;
          flags_d      = alu_flags;
          rsp0_valid_d = ~grant_c;
          rsp1_valid_d = grant_c;
        end
      end
      RESP: begin
        if ((rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready)) begin
          state_d      = IDLE;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset drops any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      res_q        <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
    end
  end

  // The shared result register feeds both response ports; only one is ever valid
  always_comb begin
    rsp0_valid = rsp0_valid_q;
    rsp1_valid = rsp1_valid_q;
    rsp0_res   = res_q;
    rsp1_res   = res_q;
    rsp0_flags = flags_q;
    rsp1_flags = flags_q;
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: directed vectors, scoreboard queue filled at
// request acceptance and drained by a monitor at response handshakes.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_res, rsp1_res;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic [31:0] alu_src1, alu_src2, alu_res;
  logic [2:0]  alu_op;
  logic [3:0]  alu_flags;
  logic [32:0] sum33;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;
  exp_t sb_q[$];

  int exp_order[4];

  always #5 clk = ~clk;

  alu_share_arb #(.N(32), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_res(rsp0_res), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_res(rsp1_res), .rsp1_flags(rsp1_flags),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .alu_res(alu_res), .alu_flags(alu_flags)
  );

  // Reference ALU: 000 add, 001 sub (C = borrow), 101 signed slt; flags {V,C,N,Z}
  always_comb begin
    sum33     = '0;
    alu_res   = '0;
    alu_flags = '0;
    case (alu_op)
      3'b000: begin
        sum33        = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_res      = sum33[31:0];
        alu_flags[2] = sum33[32];
        alu_flags[3] = (alu_src1[31] == alu_src2[31]) && (sum33[31] != alu_src1[31]);
      end
      3'b001: begin
        sum33        = {1'b0, alu_src1} - {1'b0, alu_src2};
        alu_res      = sum33[31:0];
        alu_flags[2] = sum33[32];
        alu_flags[3] = (alu_src1[31] != alu_src2[31]) && (sum33[31] != alu_src1[31]);
      end
      3'b101: alu_res = {31'b0, ($signed(alu_src1) < $signed(alu_src2))};
      default: alu_res = '0;
    endcase
    alu_flags[1] = alu_res[31];
    alu_flags[0] = (alu_res == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input int port, input logic [31:0] res, input logic [3:0] flags);
    exp_t e;
    e.port  = port;
    e.res   = res;
    e.flags = flags;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input int port, input logic [31:0] res, input logic [3:0] flags);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_unexpected_rsp", 32'(port), 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      chk("rsp_port", 32'(port), 32'(e.port));
      chk("rsp_res", res, e.res);
      chk("rsp_flags", 32'(flags), 32'(e.flags));
    end
  endtask

  // Monitor: a response handshake completes at the next rising edge
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid && rsp0_ready) pop_check(0, rsp0_res, rsp0_flags);
      if (rsp1_valid && rsp1_ready) pop_check(1, rsp1_res, rsp1_flags);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, i0, i1, g;
`ifdef ALU_ARB_RR_EN
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`endif
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_src1 = '0; req0_src2 = '0; req0_op = '0;
    req1_src1 = '0; req1_src2 = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_res", rsp0_res, 32'd0);
    chk("rst_rsp1_flags", 32'(rsp1_flags), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);

    // Port 0 add 5+7 with rsp0_ready held high
    tick();
    req0_valid = 1'b1; req0_src1 = 32'd5; req0_src2 = 32'd7; req0_op = 3'b000;
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("add_req0_ready_T", 32'(req0_ready), 32'd1);
    chk("add_req1_ready_T", 32'(req1_ready), 32'd0);
    push_exp(0, 32'd12, 4'b0000);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("add_rsp0_valid_T1", 32'(rsp0_valid), 32'd1);
    chk("add_rsp1_valid_T1", 32'(rsp1_valid), 32'd0);

    // T+2: back in IDLE, port 1 sub 3-3 accepted, response held 4 cycles
    tick();
    req1_valid = 1'b1; req1_src1 = 32'd3; req1_src2 = 32'd3; req1_op = 3'b001;
    rsp1_ready = 1'b0; rsp0_ready = 1'b0;
    @(negedge clk);
    chk("add_rsp0_valid_T2", 32'(rsp0_valid), 32'd0);
    chk("sub_req1_ready", 32'(req1_ready), 32'd1);
    push_exp(1, 32'd0, 4'b0001);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_src1 = 32'd100; req0_src2 = 32'd1; req0_op = 3'b000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("hold_rsp1_res", rsp1_res, 32'd0);
      chk("hold_rsp1_flags", 32'(rsp1_flags), 32'd1);
      chk("hold_req0_ready", 32'(req0_ready), 32'd0);
      chk("hold_rsp0_valid", 32'(rsp0_valid), 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("release_req0_ready", 32'(req0_ready), 32'd0);
    tick();
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    @(negedge clk);
    chk("after_hold_req0_ready", 32'(req0_ready), 32'd1);
    push_exp(0, 32'd101, 4'b0000);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    tick();

    // Contention: reset first so port 0 wins the first tie
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req1_op = 3'b000;
    @(negedge clk);
    chk("rstcyc_req0_ready", 32'(req0_ready), 32'd0);
    chk("rstcyc_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    reset = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    n = 0; i0 = 0; i1 = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      req0_src1 = 32'(i0 + 1);  req0_src2 = 32'(i0 + 1);
      req1_src1 = 32'(10 * (i1 + 1)); req1_src2 = 32'(10 * (i1 + 1));
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("dual_ready", 32'(req0_ready && req1_ready), 32'd0);
        g = req1_ready ? 1 : 0;
        chk("grant_order", 32'(g), 32'(exp_order[n]));
        if (g == 0) begin
          push_exp(0, 32'(2 * (i0 + 1)), 4'b0000);
          i0++;
        end else begin
          push_exp(1, 32'(20 * (i1 + 1)), 4'b0000);
          i1++;
        end
        n++;
      end
      tick();
    end
    chk("contention_ops", 32'(n), 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();

    // Reset the cycle after accepting port 0: result dropped
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_src1 = 32'd8; req0_src2 = 32'd8; req0_op = 3'b000;
    @(negedge clk);
    chk("rstmid_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rstmid_rsp0_valid_T1", 32'(rsp0_valid), 32'd1);
    tick();
    reset = 1'b0; rsp0_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmid_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rstmid_rsp0_res", rsp0_res, 32'd0);
      chk("rstmid_rsp0_flags", 32'(rsp0_flags), 32'd0);
      tick();
    end

    // Port 1 slt 2<9; proves IDLE after the mid-response reset
    req1_valid = 1'b1; req1_src1 = 32'd2; req1_src2 = 32'd9; req1_op = 3'b101;
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("slt_req1_ready", 32'(req1_ready), 32'd1);
    push_exp(1, 32'd1, 4'b0000);
    tick();
    req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("slt_rsp0_valid", 32'(rsp0_valid), 32'd0);
      tick();
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
